// File: rtl/i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_cmd_arbiter
//   Round-robin arbiter that picks one of NUM_REQ command requesters and
//   feeds its address/payload to a single I2C master. It watches the
//   master's idle flag to follow the transaction through start, busy and
//   return-to-idle, and reports the result with a one-cycle completion pulse.
//   A timeout guards both wait states against a stuck master.
//
// Ports
//   clk         : clock, rising edge
//   arst_n      : asynchronous active-low reset
//   req_valid   : [NUM_REQ]            per-requester command pending
//   req_addr    : [NUM_REQ*ADDR_WIDTH] packed addresses, requester i at i*ADDR_WIDTH
//   req_data    : [NUM_REQ*DATA_WIDTH] packed payloads, requester i at i*DATA_WIDTH
//   req_ready   : [NUM_REQ]            one-hot, one-cycle accept pulse
//   m_start     : start strobe to the master (one cycle)
//   m_addr      : latched address, stable from grant to next grant
//   m_data      : latched payload, stable from grant to next grant
//   m_ready     : master idle flag (high only while the master is idle)
//   done_valid  : one-cycle completion pulse
//   done_id     : index of completed requester (holds between pulses)
//   done_err    : timeout flag, qualified by done_valid (holds between pulses)
//   busy        : high whenever the FSM is not in IDLE
//   dbg_state   : current FSM state encoding (debug observation)
//
// Handshake: a requester holds req_valid together with its addr/data until
// it sees its req_ready bit high for one cycle; that cycle is the accept.
// Addr/data are captured on the grant, so anything the requester does after
// the accept does not touch the transaction in flight. Dropping req_valid
// before the accept simply withdraws the request.
// ---------------------------------------------------------------------------
module i2c_cmd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            m_start,
  output logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [DATA_WIDTH-1:0]           m_data,
  input  logic                            m_ready,
  output logic                            done_valid,
  output logic [$clog2(NUM_REQ)-1:0]      done_id,
  output logic                            done_err,
  output logic                            busy,
  output logic [2:0]                      dbg_state
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NUM_REQ - 1);
  localparam logic [IDW-1:0] IDX_ONE  = IDW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         last_grant_q, last_grant_d;
  logic [IDW-1:0]         cur_id_q, cur_id_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0]     req_ready_d;
  logic                   m_start_d;
  logic [ADDR_WIDTH-1:0]  m_addr_d;
  logic [DATA_WIDTH-1:0]  m_data_d;
  logic                   done_valid_d;
  logic [IDW-1:0]         done_id_d;
  logic                   done_err_d;

  // Round-robin search: walk forward from last_grant+1, wrapping, and take
  // the first pending requester. last_grant resets to NUM_REQ-1 so that
  // requester 0 is first in line after reset.
  logic                   found;
  logic [IDW-1:0]         win;
  logic [IDW-1:0]         idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + IDX_ONE;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state and next-output logic. Every output is a register loaded
  // from these *_d values, so each pulse lines up with the state it
  // belongs to (m_start/req_ready during ISSUE, done_valid during COMPLETE).
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    m_start_d    = 1'b0;
    m_addr_d     = m_addr;
    m_data_d     = m_data;
    done_valid_d = 1'b0;
    done_id_d    = done_id;
    done_err_d   = done_err;

    case (state_q)
      IDLE: begin
        if (m_ready && found) begin
          state_d          = ISSUE;
          req_ready_d[win] = 1'b1;
          m_start_d        = 1'b1;
          m_addr_d         = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
          m_data_d         = req_data[win*DATA_WIDTH +: DATA_WIDTH];
          cur_id_d         = win;
        end
      end

      ISSUE: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end

      // Waiting for the master to leave idle, i.e. to accept the start.
      WAIT_BUSY: begin
        if (!m_ready) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = COMPLETE;
          done_valid_d = 1'b1;
          done_id_d    = cur_id_q;
          done_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Waiting for the master to finish and return to idle.
      WAIT_DONE: begin
        if (m_ready) begin
          state_d      = COMPLETE;
          done_valid_d = 1'b1;
          done_id_d    = cur_id_q;
          done_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = COMPLETE;
          done_valid_d = 1'b1;
          done_id_d    = cur_id_q;
          done_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // done_valid is high in this cycle; no grant can be made here.
      COMPLETE: begin
        state_d      = IDLE;
        last_grant_d = cur_id_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_IDX;
      cur_id_q     <= '0;
      cnt_q        <= '0;
      req_ready    <= '0;
      m_start      <= 1'b0;
      m_addr       <= '0;
      m_data       <= '0;
      done_valid   <= 1'b0;
      done_id      <= '0;
      done_err     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      cnt_q        <= cnt_d;
      req_ready    <= req_ready_d;
      m_start      <= m_start_d;
      m_addr       <= m_addr_d;
      m_data       <= m_data_d;
      done_valid   <= done_valid_d;
      done_id      <= done_id_d;
      done_err     <= done_err_d;
      busy         <= (state_d != IDLE);
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_arbiter
//   Directed bench for i2c_cmd_arbiter (NUM_REQ=4, 7-bit addr, 8-bit data,
//   TIMEOUT=8). Inputs are driven and outputs sampled on the falling edge.
//   Requester i always presents addr 0x50+i and data 0xA5+0x11*i; a
//   queue of expected done_id values is filled at grant and drained at
//   completion.
// ---------------------------------------------------------------------------
module tb_i2c_cmd_arbiter;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             m_start;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  logic             m_ready;
  logic             done_valid;
  logic [1:0]       done_id;
  logic             done_err;
  logic             busy;
  logic [2:0]       dbg_state;

  i2c_cmd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];

  logic [NR*AW-1:0] addr_base;
  logic [NR*DW-1:0] data_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // mode 0: normal master (busy for busy_len cycles)
  // mode 1: master stays idle after m_start
  // mode 2: master stays busy forever
  task automatic do_txn(input logic [NR-1:0] valid, input int exp_id,
                        input int mode, input int busy_len);
    bit         seen;
    bit         dseen;
    int         n;
    logic [1:0] exp_done;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    ea = addr_base[exp_id*AW +: AW];
    ed = data_base[exp_id*DW +: DW];
    req_valid = valid;
    m_ready   = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1;
    end
    check("grant_seen", 32'(seen), 32'd1);
    if (!seen) return;
    exp_q.push_back(2'(exp_id));
    check("req_ready_onehot", 32'(req_ready), 32'(1 << exp_id));
    check("m_start_at_grant", 32'(m_start), 32'd1);
    check("m_addr_at_grant", 32'(m_addr), 32'(ea));
    check("m_data_at_grant", 32'(m_data), 32'(ed));
    // Requester side changes after the accept must not leak through.
    req_addr = ~addr_base;
    req_data = ~data_base;
    if (mode != 1) m_ready = 1'b0;
    @(negedge clk);
    n = 1;
    check("m_start_one_cycle", 32'(m_start), 32'd0);
    check("req_ready_one_cycle", 32'(req_ready), 32'd0);
    if (mode == 0) begin
      repeat (busy_len) @(negedge clk);
      m_ready = 1'b1;
      n = 0;
    end
    dseen = 0;
    for (int i = 0; i < 40 && !dseen; i++) begin
      @(negedge clk);
      n++;
      if (done_valid) dseen = 1;
    end
    check("done_seen", 32'(dseen), 32'd1);
    if (dseen) begin
      if (mode == 0) check("done_latency", 32'(n), 32'd1);
      if (mode == 1) check("timeout_busy_latency", 32'(n), 32'(TO + 1));
      if (mode == 2) check("timeout_done_latency", 32'(n), 32'(TO + 2));
      exp_done = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd0;
      check("done_id", 32'(done_id), 32'(exp_done));
      check("done_err", 32'(done_err), (mode == 0) ? 32'd0 : 32'd1);
      check("m_addr_stable", 32'(m_addr), 32'(ea));
      check("m_data_stable", 32'(m_data), 32'(ed));
    end
    req_addr = addr_base;
    req_data = data_base;
    m_ready  = 1'b1;
    @(negedge clk);
    check("done_pulse_one_cycle", 32'(done_valid), 32'd0);
    check("done_id_hold", 32'(done_id), 32'(exp_id));
    check("done_err_hold", 32'(done_err), (mode == 0) ? 32'd0 : 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_m_start"},    32'(m_start),    32'd0);
    check({tag, "_m_addr"},     32'(m_addr),     32'd0);
    check({tag, "_m_data"},     32'(m_data),     32'd0);
    check({tag, "_req_ready"},  32'(req_ready),  32'd0);
    check({tag, "_done_valid"}, 32'(done_valid), 32'd0);
    check({tag, "_done_id"},    32'(done_id),    32'd0);
    check({tag, "_done_err"},   32'(done_err),   32'd0);
    check({tag, "_state"},      32'(dbg_state),  32'd0);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < NR; i++) begin
      addr_base[i*AW +: AW] = 7'h50 + 7'(i);
      data_base[i*DW +: DW] = 8'hA5 + 8'(17 * i);
    end
    req_valid = '0;
    req_addr  = addr_base;
    req_data  = data_base;
    m_ready   = 1'b1;

    // reset values before any clock edge
    #2;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // fairness with all four pending
    for (int i = 0; i < 8; i++) do_txn(4'b1111, i % 4, 0, 1 + (i % 3));

    // wrap-around: last grant was 3, so 1 then 2
    do_txn(4'b0110, 1, 0, 2);
    do_txn(4'b0110, 2, 0, 1);

    // single request, requester 0 (addr 0x50, data 0xA5)
    do_txn(4'b0001, 0, 0, 3);

    // master not idle: nothing is granted
    req_valid = 4'b0001;
    m_ready   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_grant_req_ready", 32'(req_ready), 32'd0);
      check("no_grant_busy", 32'(busy), 32'd0);
    end
    do_txn(4'b0001, 0, 0, 1);

    // master hung idle, then hung busy, then a normal one
    do_txn(4'b0010, 1, 1, 0);
    do_txn(4'b0100, 2, 2, 0);
    do_txn(4'b1000, 3, 0, 2);

    // reset during WAIT_DONE
    req_valid = 4'b0010;
    m_ready   = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1;
    end
    check("abort_grant_seen", 32'(seen), 32'd1);
    check("abort_grant_id", 32'(req_ready), 32'b0010);
    m_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dbg_state == 3'd3) seen = 1;
    end
    check("abort_in_wait_done", 32'(seen), 32'd1);
    arst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    req_valid = '0;
    m_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done_valid), 32'd0);
    end
    arst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done_after", 32'(done_valid), 32'd0);
    do_txn(4'b1111, 0, 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
